// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type and default operand width shared by the serial adder.
package serial_adder_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int SA_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/fulladder.sv
// fulladder: single-bit full adder slice.
module fulladder (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic c_out,
    output logic s_out
);
    assign s_out = a_in ^ b_in ^ c_in;
    assign c_out = (a_in & b_in) | (c_in & (a_in ^ b_in));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, one bit per cycle through a single full-adder slice.
// Define SERIAL_ADDER_OVF_EN to add the two's-complement overflow output ovf_out.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] s_out,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf_out,
`endif
    output logic             c_out
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, s_q, s_d;
    logic             carry_q, carry_d, co_q, co_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_c, last;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    fulladder u_fa (
        .a_in (a_q[0]),
        .b_in (b_q[0]),
        .c_in (carry_q),
        .c_out(fa_c),
        .s_out(fa_s)
    );

    assign last = cnt_q == CW'(WIDTH - 1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        s_d     = s_q;
        carry_d = carry_q;
        co_d    = co_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: if (start_in) begin
                a_d     = a_in;
                b_d     = b_in;
                carry_d = c_in;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                // results are published on the final shift edge so they are valid while done_out is high
                if (last) begin
                    state_d = DONE;
                    s_d     = sum_d;
                    co_d    = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_c;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy_out = state_q == SHIFT;
    assign done_out = state_q == DONE;
    assign s_out    = s_q;
    assign c_out    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf_out  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=8), table vectors plus random operands.
// Checks ovf_out as well when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0, b_in = '0;
    logic         c_in = 1'b0;
    logic         busy_out, done_out, c_out;
    logic [W-1:0] s_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf_out;
`endif

    int checks = 0;
    int failures = 0;
    logic [W-1:0] prev_s = '0;
    logic         prev_c = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk_in  (clk),
        .rst_in  (rst),
        .start_in(start),
        .a_in    (a_in),
        .b_in    (b_in),
        .c_in    (c_in),
        .busy_out(busy_out),
        .done_out(done_out),
        .s_out   (s_out),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf_out (ovf_out),
`endif
        .c_out   (c_out)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] s;
        logic         co;
        logic         v;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // {ovf, carry, sum} from plain integer addition and sign rules
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] t;
        logic       v;
        t = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        v = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return {v, t};
    endfunction

    function automatic logic get_ovf();
`ifdef SERIAL_ADDER_OVF_EN
        return ovf_out;
`else
        return 1'b0;
`endif
    endfunction

    // Called right after a negedge; start is accepted on the next posedge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit mid,
                          output logic [W-1:0] s, output logic co, output logic v, output int lat);
        int n;
        start = 1'b1; a_in = a; b_in = b; c_in = c;
        @(negedge clk);
        start = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom); c_in = 1'($urandom);
        n = 1;
        while (!done_out && n < 20) begin
            chk("busy_during_shift", {31'd0, busy_out}, 32'd1);
            chk("s_hold", {24'd0, s_out}, {24'd0, prev_s});
            chk("c_hold", {31'd0, c_out}, {31'd0, prev_c});
            if (mid && n == 3) begin
                start = 1'b1; a_in = ~a; b_in = ~b; c_in = ~c;
            end else
                start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, done_out}, 32'd1);
        chk("busy_at_done", {31'd0, busy_out}, 32'd0);
        lat = n;
        s = s_out; co = c_out; v = get_ovf();
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done_out}, 32'd0);
        if (mid) begin
            for (int i = 0; i < 12; i++) begin
                chk("no_second_done", {31'd0, done_out}, 32'd0);
                chk("no_second_busy", {31'd0, busy_out}, 32'd0);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        vec_t vecs[$];
        logic [W-1:0] s, a, b;
        logic         co, v, c;
        logic [W+1:0] m;
        int           lat;

        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0});

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        chk("rst_done", {31'd0, done_out}, 32'd0);
        chk("rst_s", {24'd0, s_out}, 32'd0);
        chk("rst_c", {31'd0, c_out}, 32'd0);
        chk("rst_ovf", {31'd0, get_ovf()}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, s, co, v, lat);
            chk($sformatf("vec%0d_latency", i), lat, W + 1);
            chk($sformatf("vec%0d_s", i), {24'd0, s}, {24'd0, vecs[i].s});
            chk($sformatf("vec%0d_c", i), {31'd0, co}, {31'd0, vecs[i].co});
`ifdef SERIAL_ADDER_OVF_EN
            chk($sformatf("vec%0d_ovf", i), {31'd0, v}, {31'd0, vecs[i].v});
`endif
            prev_s = vecs[i].s; prev_c = vecs[i].co;
        end

        run_op(8'h3C, 8'h21, 1'b0, 1'b1, s, co, v, lat);
        chk("mid_start_s", {24'd0, s}, 32'h5D);
        chk("mid_start_c", {31'd0, co}, 32'd0);
        prev_s = 8'h5D; prev_c = 1'b0;

        run_op(8'h12, 8'h34, 1'b0, 1'b0, s, co, v, lat);
        chk("pre_rst_s", {24'd0, s}, 32'h46);
        start = 1'b1; a_in = 8'h5A; b_in = 8'h33; c_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_rst", {31'd0, busy_out}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy_out}, 32'd0);
        chk("mid_rst_done", {31'd0, done_out}, 32'd0);
        chk("mid_rst_s", {24'd0, s_out}, 32'd0);
        chk("mid_rst_c", {31'd0, c_out}, 32'd0);
        chk("mid_rst_ovf", {31'd0, get_ovf()}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_s = '0; prev_c = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("post_rst_no_done", {31'd0, done_out}, 32'd0);
            chk("post_rst_no_busy", {31'd0, busy_out}, 32'd0);
            @(negedge clk);
        end
        run_op(8'h03, 8'h04, 1'b0, 1'b0, s, co, v, lat);
        chk("post_rst_s", {24'd0, s}, 32'h07);
        chk("post_rst_c", {31'd0, co}, 32'd0);
        prev_s = 8'h07; prev_c = 1'b0;

        for (int i = 0; i < 256; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            m = model(a, b, c);
            run_op(a, b, c, 1'b0, s, co, v, lat);
            chk("rand_latency", lat, W + 1);
            chk("rand_s", {24'd0, s}, {24'd0, m[W-1:0]});
            chk("rand_c", {31'd0, co}, {31'd0, m[W]});
`ifdef SERIAL_ADDER_OVF_EN
            chk("rand_ovf", {31'd0, v}, {31'd0, m[W+1]});
`endif
            prev_s = m[W-1:0]; prev_c = m[W];
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk_in  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_in  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start_in  input  1  request to begin an addition, sampled only in IDLE.
REQ-005 The block SHALL have port a_in  input  WIDTH  operand A, captured when start is accepted.
REQ-006 The block SHALL have port b_in  input  WIDTH  operand B, captured when start is accepted.
REQ-007 The block SHALL have port c_in  input  1  carry-in, captured when start is accepted.
REQ-008 The block SHALL have port busy_out  output  1  high while bits are being added.
REQ-009 The block SHALL have port done_out  output  1  one-cycle pulse when a result completes.
REQ-010 The block SHALL have port s_out  output  WIDTH  sum of the last completed addition.
REQ-011 The block SHALL have port c_out  output  1  carry-out of the last completed addition.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE, with IDLE as the reset state.
REQ-013 In IDLE with start_in=1, the block SHALL load a_in and b_in into shift registers, load c_in into the carry flop, clear the bit counter, and go to SHIFT.
REQ-014 Each SHIFT cycle SHALL add the LSBs of both shift registers and the carry flop through one full-adder bit slice.
REQ-015 On the same edge, the sum bit SHALL enter the MSB of the sum shift register, the operand registers SHALL shift right by 1, the carry flop SHALL take the slice carry-out, and the counter SHALL increment.
REQ-016 After exactly WIDTH SHIFT cycles, the FSM SHALL go to DONE, loading s_out from the sum shift register and c_out from the carry.
REQ-017 DONE SHALL last one cycle, assert done_out, and return to IDLE unconditionally.
REQ-018 Latency SHALL be fixed: with start accepted at edge k, busy_out is high for cycles k+1..k+WIDTH and done_out is high for cycle k+WIDTH+1 only.
REQ-019 start_in SHALL be ignored in SHIFT and DONE; a new start SHALL be accepted in the IDLE cycle after DONE (back-to-back throughput of one result per WIDTH+2 cycles).
REQ-020 s_out and c_out SHALL hold their value until the next DONE, staying stable during a following operation.
REQ-021 Arithmetic SHALL be unsigned modulo 2^WIDTH, with c_out as bit WIDTH of a_in+b_in+c_in.
REQ-022 a_in, b_in and c_in changing after start is accepted SHALL NOT affect the result.

Reset
REQ-023 rst_in=1 SHALL immediately force state IDLE and set busy_out=0, done_out=0, s_out=0, c_out=0, and clear the counter, carry and shift registers.
REQ-024 A reset during SHIFT SHALL abandon the operation with no done_out pulse.
REQ-025 The first start SHALL be accepted on the first rising edge after rst_in deasserts.

Configuration
REQ-026 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add output ovf_out (1 bit, reset 0), loaded at DONE as carry-into-MSB XOR carry-out-of-MSB (two's-complement overflow) and held like s_out.
REQ-027 Without SERIAL_ADDER_OVF_EN, the block SHALL have no ovf_out port and no overflow logic, and all other behaviour SHALL be identical.

Structure
REQ-028 Package serial_adder_pkg SHALL hold the state enum type (IDLE, SHIFT, DONE) and the default width constant SA_WIDTH_DEFAULT=8.
REQ-029 The bit slice SHALL be one instance of the existing fulladder module (ports a_in, b_in, c_in, c_out, s_out), with no duplicated adder logic.
REQ-030 The counter width SHALL be $clog2(WIDTH+1) bits.

Verification
REQ-031 The bench SHALL check a_in=0x00, b_in=0x00, c_in=0 -> done_out after 9 cycles, s_out=0x00, c_out=0.
REQ-032 The bench SHALL check a_in=0xFF, b_in=0x01, c_in=0 -> s_out=0x00, c_out=1.
REQ-033 The bench SHALL check a_in=0xA5, b_in=0x5A, c_in=1 -> s_out=0x00, c_out=1; with the macro, also a_in=0x7F, b_in=0x01 -> ovf_out=1.
REQ-034 The bench SHALL pulse start_in during SHIFT with different operands -> the result still matches the first operands and exactly one done_out pulse occurs.
REQ-035 The bench SHALL assert rst_in at SHIFT cycle 4 -> all outputs 0 with no done_out pulse; then 0x03+0x04 -> s_out=0x07, c_out=0.
REQ-036 The bench SHALL check 256 random operand pairs plus all 8 single-bit c_in/a_in/b_in LSB combinations against a+b+c.
